// File: rtl/jsv_pkg.sv
// Shared types and constants for the JSV raster scan controller.
package jsv_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int I_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_t;

  function automatic logic [I_W-1:0] clamp_iter(input logic [I_W-1:0] iter,
                                                input logic [I_W-1:0] ceiling);
    if (iter > ceiling) begin
      return ceiling;
    end else begin
      return iter;
    end
  endfunction

endpackage

// File: rtl/jsv_pixel_counter.sv
// Raster x/y counter; x runs fastest, both wrap at the frame edge.
module jsv_pixel_counter
  import jsv_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
  localparam logic [X_W-1:0] X_ONE  = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

  logic [X_W-1:0] x_r;
  logic [Y_W-1:0] y_r;

  // Raster position register; clear takes priority over advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (clear) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (advance) begin
      if (x_r == X_LAST) begin
        x_r <= {X_W{1'b0}};
        y_r <= (y_r == Y_LAST) ? {Y_W{1'b0}} : (y_r + Y_ONE);
      end else begin
        x_r <= x_r + X_ONE;
      end
    end
  end

  assign x    = x_r;
  assign y    = y_r;
  assign last = (x_r == X_LAST) && (y_r == Y_LAST);

endmodule

// File: rtl/jsv_scan_ctrl.sv
// Frame scan sequencer: issues one pixel at a time to the iteration engine and
// forwards each result to the bitmap writer. JSV_SCAN_CONTINUOUS_EN repeats frames.
module jsv_scan_ctrl
  import jsv_pkg::*;
#(
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int MAX_ITER = 255
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           frame_done,
  output logic           calc_req,
  output logic [X_W-1:0] calc_x,
  output logic [Y_W-1:0] calc_y,
  input  logic           calc_ack,
  input  logic           calc_valid,
  input  logic [I_W-1:0] calc_iter,
  output logic           draw,
  output logic [X_W-1:0] draw_x,
  output logic [Y_W-1:0] draw_y,
  output logic [I_W-1:0] draw_i,
  input  logic           draw_ready
);

  localparam logic [I_W-1:0] ITER_CEIL = I_W'(MAX_ITER);

  scan_state_t    state_r, state_s;
  logic           cnt_clear_s, cnt_advance_s, capture_s, last_s;
  logic [X_W-1:0] x_s;
  logic [Y_W-1:0] y_s;
  logic           busy_r, frame_done_r, calc_req_r, draw_r;
  logic [I_W-1:0] draw_i_r;

  jsv_pixel_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_counter (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .clear   (cnt_clear_s),
    .advance (cnt_advance_s),
    .x       (x_s),
    .y       (y_s),
    .last    (last_s)
  );

  // Next-state decode; abort overrides every handshake seen in the same cycle.
  always_comb begin
    state_s       = state_r;
    cnt_clear_s   = 1'b0;
    cnt_advance_s = 1'b0;
    capture_s     = 1'b0;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s     = ST_ISSUE;
            cnt_clear_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (calc_ack) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (calc_valid) begin
            state_s   = ST_WRITE;
            capture_s = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_WRITE: begin
          if (draw_ready) begin
            cnt_advance_s = 1'b1;
            state_s       = last_s ? ST_DONE : ST_ISSUE;
          end else begin
            state_s = ST_WRITE;
          end
        end
        ST_DONE: begin
`ifdef JSV_SCAN_CONTINUOUS_EN
          state_s     = ST_ISSUE;
          cnt_clear_s = 1'b1;
`else
          state_s     = ST_IDLE;
`endif
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      calc_req_r   <= 1'b0;
      draw_r       <= 1'b0;
      draw_i_r     <= {I_W{1'b0}};
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s != ST_IDLE);
      frame_done_r <= (state_s == ST_DONE);
      calc_req_r   <= (state_s == ST_ISSUE);
      draw_r       <= (state_s == ST_WRITE);
      if (capture_s) begin
        draw_i_r <= clamp_iter(calc_iter, ITER_CEIL);
      end
    end
  end

  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign calc_req   = calc_req_r;
  assign calc_x     = x_s;
  assign calc_y     = y_s;
  assign draw       = draw_r;
  assign draw_x     = x_s;
  assign draw_y     = y_s;
  assign draw_i     = draw_i_r;

endmodule

// File: tb/tb_jsv_scan_ctrl.sv
// Randomized engine/writer responder around jsv_scan_ctrl, checked against raster-order expectations.
module tb_jsv_scan_ctrl;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int MAXI = 100;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic       busy, frame_done, calc_req, draw;
  logic [9:0] calc_x, draw_x;
  logic [8:0] calc_y, draw_y;
  logic       calc_ack = 1'b0, calc_valid = 1'b0, draw_ready = 1'b0;
  logic [7:0] calc_iter = 8'd0;
  logic [7:0] draw_i;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_clk = ~clk_clk;

  jsv_scan_ctrl #(.H_RES(H), .V_RES(V), .MAX_ITER(MAXI)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start), .abort(abort),
    .busy(busy), .frame_done(frame_done),
    .calc_req(calc_req), .calc_x(calc_x), .calc_y(calc_y), .calc_ack(calc_ack),
    .calc_valid(calc_valid), .calc_iter(calc_iter),
    .draw(draw), .draw_x(draw_x), .draw_y(draw_y), .draw_i(draw_i), .draw_ready(draw_ready)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_calc_req"},   32'(calc_req),   32'd0);
    check({tag, "_draw"},       32'(draw),       32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  // Runs one frame as engine + writer. stall_px holds draw_ready low 5 cycles at
  // that pixel index; abort_px aborts while waiting for that pixel's result.
  task automatic do_frame(input int max_dly, input int iter_fixed, input int stall_px, input int abort_px);
    int w, d, it, ex_i, ex_x, ex_y;
    start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    for (int k = 0; k < H * V; k++) begin
      ex_x = k % H;
      ex_y = k / H;
      w = 0;
      while (calc_req !== 1'b1 && w < 20) begin
        @(negedge clk_clk);
        w++;
      end
      check("calc_req", 32'(calc_req), 32'd1);
      if (max_dly == 0) check("pixel_latency", w, 32'd0);
      check("calc_x", 32'(calc_x), ex_x);
      check("calc_y", 32'(calc_y), ex_y);
      d = int'($urandom_range(max_dly, 0));
      repeat (d) begin
        calc_valid = 1'($urandom_range(1, 0));
        @(negedge clk_clk);
        check("req_hold", 32'(calc_req), 32'd1);
        check("req_x_hold", 32'(calc_x), ex_x);
      end
      calc_valid = 1'b0;
      calc_ack = 1'b1;
      @(negedge clk_clk);
      calc_ack = 1'b0;
      check("wait_req_low", 32'(calc_req), 32'd0);
      check("wait_draw_low", 32'(draw), 32'd0);
      it   = (iter_fixed >= 0) ? iter_fixed : int'($urandom_range(255, 0));
      ex_i = (it > MAXI) ? MAXI : it;
      if (k == abort_px) begin
        abort = 1'b1;
        calc_valid = 1'b1;
        calc_iter = 8'(it);
        @(negedge clk_clk);
        abort = 1'b0;
        calc_valid = 1'b0;
        check_quiet("abort");
        repeat (4) begin
          @(negedge clk_clk);
          check_quiet("after_abort");
        end
        return;
      end
      d = int'($urandom_range(max_dly, 0));
      repeat (d) begin
        start = 1'($urandom_range(1, 0));
        @(negedge clk_clk);
        check("wait_hold_req", 32'(calc_req), 32'd0);
        check("wait_hold_draw", 32'(draw), 32'd0);
      end
      start = 1'b0;
      calc_valid = 1'b1;
      calc_iter = 8'(it);
      @(negedge clk_clk);
      calc_valid = 1'b0;
      calc_iter = 8'($urandom_range(255, 0));
      check("draw", 32'(draw), 32'd1);
      check("draw_x", 32'(draw_x), ex_x);
      check("draw_y", 32'(draw_y), ex_y);
      check("draw_i", 32'(draw_i), ex_i);
      check("busy", 32'(busy), 32'd1);
      d = (k == stall_px) ? 5 : int'($urandom_range(max_dly, 0));
      repeat (d) begin
        @(negedge clk_clk);
        check("stall_draw", 32'(draw), 32'd1);
        check("stall_x", 32'(draw_x), ex_x);
        check("stall_i", 32'(draw_i), ex_i);
        check("stall_no_req", 32'(calc_req), 32'd0);
      end
      draw_ready = 1'b1;
      @(negedge clk_clk);
      draw_ready = 1'b0;
    end
    check("frame_done", 32'(frame_done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_draw", 32'(draw), 32'd0);
    @(negedge clk_clk);
    check("frame_done_pulse", 32'(frame_done), 32'd0);
`ifdef JSV_SCAN_CONTINUOUS_EN
    check("cont_req", 32'(calc_req), 32'd1);
    check("cont_x", 32'(calc_x), 32'd0);
    check("cont_y", 32'(calc_y), 32'd0);
    abort = 1'b1;
    @(negedge clk_clk);
    abort = 1'b0;
    check_quiet("cont_abort");
`else
    check_quiet("after_frame");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_clk);
    check_quiet("reset");
    check("reset_calc_x", 32'(calc_x), 32'd0);
    check("reset_calc_y", 32'(calc_y), 32'd0);
    check("reset_draw_i", 32'(draw_i), 32'd0);
    reset_reset_n = 1'b1;
    calc_valid = 1'b1;
    calc_ack = 1'b1;
    draw_ready = 1'b1;
    @(negedge clk_clk);
    calc_valid = 1'b0;
    calc_ack = 1'b0;
    draw_ready = 1'b0;
    check_quiet("idle_stray");

    do_frame(0, 7, -1, -1);
    do_frame(0, -1, 2, -1);
    do_frame(0, 200, -1, -1);
    repeat (2) do_frame(3, -1, -1, -1);

    do_frame(1, -1, -1, 5);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk_clk);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk_clk);
    check_quiet("abort_beats_start");
    do_frame(0, -1, -1, -1);

    start = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    calc_ack = 1'b1;
    @(negedge clk_clk);
    calc_ack = 1'b0;
    calc_valid = 1'b1;
    calc_iter = 8'd42;
    @(negedge clk_clk);
    calc_valid = 1'b0;
    check("rst_pre_draw", 32'(draw), 32'd1);
    check("rst_pre_draw_i", 32'(draw_i), 32'd42);
    #2 reset_reset_n = 1'b0;
    #1;
    check_quiet("async_reset");
    check("async_reset_draw_i", 32'(draw_i), 32'd0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    check_quiet("post_reset");
    check("post_reset_draw_x", 32'(draw_x), 32'd0);
    do_frame(2, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jsv_scan_ctrl.md
JSV_SCAN_CTRL -- requirements
Module: jsv_scan_ctrl

Interface
REQ-001 Parameter H_RES, default 640; pixels per line.
REQ-002 Parameter V_RES, default 480; lines per frame.
REQ-003 Parameter MAX_ITER, default 255; iteration ceiling, range 1..255.
REQ-004 Port clk_clk, input, 1; the single clock; all logic on its rising edge.
REQ-005 Port reset_reset_n, input, 1; asynchronous, active-low reset.
REQ-006 Port start, input, 1; single-cycle pulse that begins a frame scan.
REQ-007 Port abort, input, 1; synchronous cancel of the current scan.
REQ-008 Port busy, output, 1; high whenever state is not IDLE.
REQ-009 Port frame_done, output, 1; one-cycle pulse when the last pixel is written.
REQ-010 Ports calc_req (out, 1), calc_x (out, 10), calc_y (out, 9) and calc_ack (in, 1); pixel request to the iteration engine.
REQ-011 Ports calc_valid (in, 1) and calc_iter (in, 8); result from the iteration engine.
REQ-012 Ports draw (out, 1), draw_x (out, 10), draw_y (out, 9), draw_i (out, 8) and draw_ready (in, 1); write to the SDRAM bitmap writer.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT, WRITE and DONE.
REQ-014 IDLE: when start=1, clear x and y to 0 and go to ISSUE on the next cycle. start is ignored in every other state.
REQ-015 ISSUE: drive calc_req=1 with calc_x/calc_y held stable. Go to WAIT in the cycle calc_ack=1 is sampled.
REQ-016 WAIT: calc_req=0. When calc_valid=1, capture min(calc_iter, MAX_ITER) into draw_i and go to WRITE.
REQ-017 calc_valid sampled in any state other than WAIT SHALL be ignored.
REQ-018 WRITE: drive draw=1 with draw_x/draw_y/draw_i held stable until draw_ready=1 is sampled. That cycle completes the write.
REQ-019 On write completion, increment x. When x=H_RES-1, wrap x to 0 and increment y.
REQ-020 If the completed write was at x=H_RES-1 and y=V_RES-1, go to DONE; otherwise go to ISSUE.
REQ-021 DONE: assert frame_done for exactly one cycle, then go to IDLE.
REQ-022 abort=1 in any state SHALL force IDLE on the next cycle: calc_req=0, draw=0, no frame_done pulse.
REQ-023 If abort and start are both 1 in IDLE, abort wins and the state stays IDLE.
REQ-024 A calc_ack or draw_ready arriving in the same cycle as abort SHALL be discarded.
REQ-025 Pixel latency, start to first calc_req = 1 cycle. Each pixel takes at least 3 cycles (ISSUE, WAIT, WRITE) when ack, valid and ready are immediate.
REQ-026 Outputs are registered; no combinational path from any input to any output.

Reset
REQ-027 While reset_reset_n=0: state=IDLE; busy, frame_done, calc_req and draw = 0; calc_x, calc_y, draw_x, draw_y and draw_i = 0.
REQ-028 Reset asserted mid-scan SHALL drop calc_req and draw immediately (asynchronously), with no frame_done.

Configuration
REQ-029 Macro JSV_SCAN_CONTINUOUS_EN.
- Defined: DONE pulses frame_done, then goes to ISSUE with x=y=0, repeating frames until abort.
- Undefined: DONE returns to IDLE and waits for start.

Structure
REQ-030 Package jsv_pkg SHALL hold:
- the state enum;
- the H_RES/V_RES defaults;
- the coordinate widths (X_W=10, Y_W=9, I_W=8).
REQ-031 Sub-module jsv_pixel_counter SHALL provide the x/y raster counter: inputs clear and advance; outputs x, y and last (high at H_RES-1, V_RES-1).

Verification
REQ-032 Test 1, full frame, H_RES=4, V_RES=2. start with calc_ack, calc_valid and draw_ready tied high, calc_iter=7 -> 8 draws in raster order (0,0)..(3,1), all draw_i=7; frame_done one cycle after the (3,1) write; busy low afterwards.
REQ-033 Test 2, back-pressure. Hold draw_ready=0 for 5 cycles at pixel (2,0) -> draw, draw_x=2 and draw_i stay stable for those 5 cycles, and no new calc_req is issued.
REQ-034 Test 3, clamp. MAX_ITER=100, calc_iter=200 -> draw_i=100.
REQ-035 Test 4, abort. abort at pixel (1,1) while in WAIT -> state IDLE next cycle, calc_req=0 and draw=0, no frame_done; a subsequent start restarts at (0,0).
REQ-036 Test 5, reset. reset_reset_n low while draw=1 -> draw=0 with no clock edge; after release busy=0 and all outputs at 0.
REQ-037 Test 6, continuous. With JSV_SCAN_CONTINUOUS_EN, H_RES=2, V_RES=1 -> frame_done pulses after every second draw; the third draw is at (0,0).
